// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment driver: sequential double-dabble binary->BCD converter
// with load/busy handshake, leading-zero blanking, overflow dashes and digit scan.
module seg_display_scan #(
   parameter int DIGITS        = 8,
   parameter int IN_WIDTH      = 16,
   parameter int CLK_DIV       = 125000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_WIDTH-1:0] number,
   input  logic                load,
   input  logic [DIGITS-1:0]   dp_mask,
   output logic                busy,
   output logic [7:0]          data,
   output logic [DIGITS-1:0]   anode
);

   localparam int BW    = DIGITS * 4;
   localparam int SW    = BW + IN_WIDTH;
   localparam int CNT_W = $clog2(IN_WIDTH + 1);
   localparam int REF_W = $clog2(CLK_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_nxt;
   logic [SW-1:0]      shreg;
   logic [SW-1:0]      sh_adj;
   logic [SW-1:0]      sh_next;
   logic               ovf_acc;
   logic               ovf_final;
   logic [CNT_W-1:0]   shift_cnt;
   logic               last_shift;
   logic [BW-1:0]      disp_bcd;
   logic               disp_ovf;
   logic [REF_W-1:0]   ref_cnt;
   logic [IDX_W-1:0]   digit_idx;
   logic [DIGITS-1:0]  blank;
   logic               higher_zero;
   logic [3:0]         cur_nib;
   logic               cur_blank;
   logic               cur_dp;
   logic [6:0]         seg;

   // Add-3 on every BCD nibble >= 5, then shift {bcd, binary} left one place
   always_comb begin
      sh_adj = shreg;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (shreg[IN_WIDTH + 4*i +: 4] >= 4'd5)
            sh_adj[IN_WIDTH + 4*i +: 4] = shreg[IN_WIDTH + 4*i +: 4] + 4'd3;
      end
      sh_next   = sh_adj << 1;
      ovf_final = ovf_acc | sh_adj[SW-1];
   end

   assign last_shift = (shift_cnt == CNT_W'(IN_WIDTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE:  if (load) state_nxt = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (last_shift) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg     <= '0;
         ovf_acc   <= 1'b0;
         shift_cnt <= '0;
         disp_bcd  <= '0;
         disp_ovf  <= 1'b0;
      end else if (state == IDLE) begin
         if (load) begin
            shreg     <= {{BW{1'b0}}, number};
            ovf_acc   <= 1'b0;
            shift_cnt <= '0;
         end
      end else begin
         shreg     <= sh_next;
         ovf_acc   <= ovf_final;
         shift_cnt <= shift_cnt + CNT_W'(1);
         // Commit on the final shift edge, together with busy falling
         if (last_shift) begin
            disp_bcd <= sh_next[SW-1 -: BW];
            disp_ovf <= ovf_final;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_cnt   <= '0;
         digit_idx <= '0;
      end else if (ref_cnt == REF_W'(CLK_DIV - 1)) begin
         ref_cnt   <= '0;
         digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end else begin
         ref_cnt <= ref_cnt + REF_W'(1);
      end
   end

   // Walk from the top nibble down; a digit blanks while everything above it is zero
   always_comb begin
      blank       = '0;
      higher_zero = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         higher_zero = higher_zero & (disp_bcd[4*(DIGITS-1-k) +: 4] == 4'd0);
         blank[DIGITS-1-k] = (BLANK_LEADING != 0) && higher_zero && (k != DIGITS - 1);
      end
   end

   always_comb begin
      anode     = '1;
      cur_nib   = '0;
      cur_blank = 1'b0;
      cur_dp    = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (digit_idx == IDX_W'(i)) begin
            anode[i]  = 1'b0;
            cur_nib   = disp_bcd[4*i +: 4];
            cur_blank = blank[i];
            cur_dp    = dp_mask[i];
         end
      end
   end

   always_comb begin
      case (cur_nib)
         4'd0:    seg = 7'b0000001;
         4'd1:    seg = 7'b1001111;
         4'd2:    seg = 7'b0010010;
         4'd3:    seg = 7'b0000110;
         4'd4:    seg = 7'b1001100;
         4'd5:    seg = 7'b0100100;
         4'd6:    seg = 7'b0100000;
         4'd7:    seg = 7'b0001111;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0000100;
         default: seg = 7'b1111111;
      endcase
   end

   always_comb begin
      if (disp_ovf)       data = {~cur_dp, 7'b1111110};
      else if (cur_blank) data = {~cur_dp, 7'b1111111};
      else                data = {~cur_dp, seg};
   end

endmodule
